// File: rtl/wcoder_pkg.sv
// Shared definitions for the weighted-sum coder: sequencer FSM states,
// default frame geometry and the result tag layout used by the serializer.
package wcoder_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_GAP    = 2'd2,
    S_LINE   = 2'd3
  } state_t;

  // Default geometry, shared with the coder datapath and serializer
  localparam int unsigned DEF_COL_BLK_W    = 500;
  localparam int unsigned DEF_COL_W        = 9;
  localparam int unsigned DEF_NUM_COL_BLKS = 4;
  localparam int unsigned DEF_ROW_BLK_H    = 3;
  localparam int unsigned DEF_NUM_ROW_BLKS = 4;
  localparam int unsigned DEF_BLK_W        = 2;

  // Result tag layout {partial?, blk_row, blk_col, line_in_blk}
  localparam int unsigned TAG_LINE_LSB = 0;
  localparam int unsigned TAG_COL_LSB  = DEF_BLK_W;
  localparam int unsigned TAG_ROW_LSB  = 2 * DEF_BLK_W;
  localparam int unsigned TAG_PART_BIT = 3 * DEF_BLK_W;
  localparam int unsigned TAG_W        = 3 * DEF_BLK_W;

endpackage

// File: rtl/wcoder_res_hs.sv
// Result holding register with req/ack handshake and sticky overrun flag.
//   pclk, rst_n : clock, async active-low reset
//   load, din   : a block finished this cycle, with its payload
//   ack         : consumer accepted the held payload
//   ovr_clr     : clear the overrun flag (start of frame)
//   req, dout   : held payload valid / payload
//   overrun     : a block finished while the previous one was still unaccepted
module wcoder_res_hs #(
  parameter int unsigned DW = 6
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          ack,
  input  logic          ovr_clr,
  output logic          req,
  output logic [DW-1:0] dout,
  output logic          overrun
);

  // A new payload may replace the held one only if the slot is free or
  // being accepted this very cycle; otherwise it is dropped and flagged.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      req     <= 1'b0;
      dout    <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        if (!req || ack) begin
          req  <= 1'b1;
          dout <= din;
        end else begin
          overrun <= 1'b1;
        end
      end else if (ack) begin
        req <= 1'b0;
      end
      if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wcoder_sched.sv
// Frame/line sequencer for the weighted-sum coder on the camera pixel clock.
// Tracks vsync/href, drives per-pixel accumulate controls and hands each
// finished column block's position tag to the serializer via req/ack.
//   pclk, rst_n       : pixel clock, async active-low reset
//   vsync, href       : frame sync (high in vblank), line valid
//   acc_en, acc_clr   : accumulate din / load din (same cycle as din)
//   col_idx           : pixel index within the current column block
//   res_req, res_tag  : finished block valid / {blk_row, blk_col, line_in_blk}
//   res_ack           : serializer accepted res_tag
//   overrun           : sticky, a block finished while res_req was unacknowledged
//   frame_done        : one-cycle pulse at the end of the active frame
// Optional build macro WCODER_SCHED_PARTIAL_EN: a line ending mid-block emits
// a partial result; res_tag gains a partial flag MSB and part_len is added.
module wcoder_sched
  import wcoder_pkg::*;
#(
  parameter int unsigned COL_BLK_W    = DEF_COL_BLK_W,
  parameter int unsigned COL_W        = DEF_COL_W,
  parameter int unsigned NUM_COL_BLKS = DEF_NUM_COL_BLKS,
  parameter int unsigned ROW_BLK_H    = DEF_ROW_BLK_H,
  parameter int unsigned NUM_ROW_BLKS = DEF_NUM_ROW_BLKS,
  parameter int unsigned BLK_W        = DEF_BLK_W
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             href,
  output logic             acc_en,
  output logic             acc_clr,
  output logic [COL_W-1:0] col_idx,
  output logic             res_req,
`ifdef WCODER_SCHED_PARTIAL_EN
  output logic [3*BLK_W:0] res_tag,
  output logic [COL_W-1:0] part_len,
`else
  output logic [3*BLK_W-1:0] res_tag,
`endif
  input  logic             res_ack,
  output logic             overrun,
  output logic             frame_done
);

  // Block counters need one extra bit to hold their saturation value
  localparam int unsigned CNT_W = BLK_W + 1;
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COL_BLK_W - 1);
  localparam logic [CNT_W-1:0] COL_BLKS  = CNT_W'(NUM_COL_BLKS);
  localparam logic [CNT_W-1:0] ROW_BLKS  = CNT_W'(NUM_ROW_BLKS);
  localparam logic [BLK_W-1:0] LINE_LAST = BLK_W'(ROW_BLK_H - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] blk_col, blk_row;
  logic [BLK_W-1:0] line_in_blk;
  logic             active, line_end, frame_start, frame_abort;
  logic             blk_done, load;
  logic [3*BLK_W-1:0] tag_now;

  // State register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next state and frame/line event strobes
  always_comb begin
    state_d     = state;
    line_end    = 1'b0;
    frame_start = 1'b0;
    frame_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (vsync) state_d = S_VBLANK;
      end
      S_VBLANK: begin
        if (!vsync) begin
          state_d     = S_GAP;
          frame_start = 1'b1;
        end
      end
      S_GAP: begin
        if (vsync) begin
          state_d     = S_VBLANK;
          frame_abort = 1'b1;
        end else if (href) begin
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        if (vsync) begin
          state_d     = S_VBLANK;
          frame_abort = 1'b1;
        end else if (!href) begin
          state_d  = S_GAP;
          line_end = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath controls, combinational so they line up with din
  assign active   = (state == S_GAP) || (state == S_LINE);
  assign acc_en   = href && active && (blk_col < COL_BLKS) && (blk_row < ROW_BLKS);
  assign acc_clr  = acc_en && (col_idx == '0);
  assign blk_done = acc_en && (col_idx == COL_LAST);
  assign tag_now  = {blk_row[BLK_W-1:0], blk_col[BLK_W-1:0], line_in_blk};

  // Pixel/column/line/row counters and frame_done pulse
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx     <= '0;
      blk_col     <= '0;
      line_in_blk <= '0;
      blk_row     <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_abort;
      if (line_end || frame_abort) begin
        col_idx <= '0;
        blk_col <= '0;
      end else if (active && href) begin
        if (col_idx == COL_LAST) begin
          col_idx <= '0;
          if (blk_col < COL_BLKS) blk_col <= blk_col + CNT_W'(1);
        end else begin
          col_idx <= col_idx + COL_W'(1);
        end
      end
      if (frame_start) begin
        line_in_blk <= '0;
        blk_row     <= '0;
      end else if (line_end && (blk_row < ROW_BLKS)) begin
        if (line_in_blk == LINE_LAST) begin
          line_in_blk <= '0;
          blk_row     <= blk_row + CNT_W'(1);
        end else begin
          line_in_blk <= line_in_blk + BLK_W'(1);
        end
      end
    end
  end

`ifdef WCODER_SCHED_PARTIAL_EN
  localparam int unsigned PW = 3 * BLK_W + 1 + COL_W;

  logic          acc_q, part_done;
  logic [PW-1:0] payload, held;

  // acc_q remembers whether the last pixel of the line was accumulated
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) acc_q <= 1'b0;
    else        acc_q <= acc_en;
  end

  assign part_done = line_end && acc_q && (col_idx != '0);
  assign load      = blk_done || part_done;
  assign payload   = {part_done, tag_now, part_done ? col_idx : COL_W'(COL_BLK_W)};
  assign res_tag   = held[PW-1:COL_W];
  assign part_len  = held[COL_W-1:0];
`else
  localparam int unsigned PW = 3 * BLK_W;

  logic [PW-1:0] payload, held;

  assign load    = blk_done;
  assign payload = tag_now;
  assign res_tag = held;
`endif

  wcoder_res_hs #(.DW(PW)) u_res_hs (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .load    (load),
    .din     (payload),
    .ack     (res_ack),
    .ovr_clr (frame_start),
    .req     (res_req),
    .dout    (held),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_wcoder_sched.sv
// Randomized scoreboard bench for wcoder_sched. Line lengths are random; a
// frame-level model derives the expected result tags from the geometry
// (500-pixel blocks, 4 per line, 3 lines per row block, 4 row blocks).
module tb_wcoder_sched;

  localparam int BLK_PIX  = 500;
  localparam int MAX_COLS = 4;
  localparam int LINES_RB = 3;
  localparam int MAX_LINE = 12;  // 4 row blocks x 3 lines
`ifdef WCODER_SCHED_PARTIAL_EN
  localparam int TW      = 7;
  localparam int ACK_RUN = 1;    // partial results can follow a block closely
`else
  localparam int TW      = 6;
  localparam int ACK_RUN = 2;    // random ack
`endif

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic          res_ack = 1'b0;
  logic          acc_en, acc_clr, res_req, overrun, frame_done;
  logic [8:0]    col_idx;
  logic [TW-1:0] res_tag;
`ifdef WCODER_SCHED_PARTIAL_EN
  logic [8:0]    part_len;
`endif

  int checks = 0;
  int failures = 0;
  int exp_tag_q[$];
  int exp_len_q[$];
  int ack_mode = 1;
  int line_no = 0;
  int fd_cnt = 0;
  int fd_exp = 0;

  wcoder_sched dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .href       (href),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr),
    .col_idx    (col_idx),
    .res_req    (res_req),
    .res_tag    (res_tag),
`ifdef WCODER_SCHED_PARTIAL_EN
    .part_len   (part_len),
`endif
    .res_ack    (res_ack),
    .overrun    (overrun),
    .frame_done (frame_done)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Ack driver: 0 = held low, 1 = tied high, 2 = random
  initial begin
    forever begin
      @(posedge pclk);
      #1;
      if (ack_mode == 0)      res_ack = 1'b0;
      else if (ack_mode == 1) res_ack = 1'b1;
      else                    res_ack = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every accepted result is popped and compared in order
  always @(negedge pclk) begin
    if (frame_done) fd_cnt++;
    if (rst_n && res_req && res_ack) begin
      if (exp_tag_q.size() == 0) begin
        chk("res_unexpected", int'(res_tag), -1);
      end else begin
        chk("res_tag", int'(res_tag), exp_tag_q.pop_front());
`ifdef WCODER_SCHED_PARTIAL_EN
        chk("part_len", int'(part_len), exp_len_q.pop_front());
`else
        void'(exp_len_q.pop_front());
`endif
      end
    end
  end

  task automatic push_exp(input int tag, input int len);
    exp_tag_q.push_back(tag);
    exp_len_q.push_back(len);
  endtask

  // One line of n pixels; model pushes the results this line should produce
  task automatic drive_line(input int n);
    int  row, lib, nb, bad, first_bad;
    bit  want_req, exp_acc, exp_clr;
    row = line_no / LINES_RB;
    lib = line_no % LINES_RB;
    if (line_no < MAX_LINE) begin
      nb = n / BLK_PIX;
      if (nb > MAX_COLS) nb = MAX_COLS;
      for (int c = 0; c < nb; c++) push_exp(row * 16 + c * 4 + lib, BLK_PIX);
`ifdef WCODER_SCHED_PARTIAL_EN
      if ((n / BLK_PIX) < MAX_COLS && (n % BLK_PIX) != 0)
        push_exp(64 + row * 16 + (n / BLK_PIX) * 4 + lib, n % BLK_PIX);
`endif
    end
    bad = 0;
    first_bad = -1;
    want_req = 1'b0;
    for (int p = 0; p < n; p++) begin
      @(posedge pclk);
      #1 href = 1'b1;
      @(negedge pclk);
      exp_acc = (line_no < MAX_LINE) && (p < BLK_PIX * MAX_COLS);
      exp_clr = exp_acc && (p % BLK_PIX == 0);
      if ((want_req && !res_req) || (acc_en != exp_acc) || (acc_clr != exp_clr) ||
          (exp_acc && int'(col_idx) != p % BLK_PIX)) begin
        bad++;
        if (first_bad < 0) first_bad = p;
      end
      want_req = exp_acc && (p % BLK_PIX == BLK_PIX - 1);
    end
    @(posedge pclk);
    #1 href = 1'b0;
    @(negedge pclk);
    if ((want_req && !res_req) || acc_en) begin
      bad++;
      if (first_bad < 0) first_bad = n;
    end
    chk($sformatf("line%0d_len%0d_pixel_ctrl(first_bad_px=%0d)", line_no, n, first_bad), bad, 0);
    repeat ($urandom_range(2, 10)) @(posedge pclk);
    line_no++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_tag_q.size() != 0 && k < 3000) begin
      @(posedge pclk);
      k++;
    end
    chk("results_drained", exp_tag_q.size(), 0);
    exp_tag_q.delete();
    exp_len_q.delete();
  endtask

  task automatic frame_begin();
    @(posedge pclk);
    #1 vsync = 1'b1;
    repeat (3) @(posedge pclk);
    #1 vsync = 1'b0;
    repeat (4) @(posedge pclk);
    line_no = 0;
  endtask

  task automatic frame_end();
    @(posedge pclk);
    #1 vsync = 1'b1;
    fd_exp++;
    repeat (4) @(posedge pclk);
    drain();
    chk("frame_done_cycles", fd_cnt, fd_exp);
  endtask

  initial begin
    ack_mode = 1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_acc_en", int'(acc_en), 0);
    chk("rst_acc_clr", int'(acc_clr), 0);
    chk("rst_col_idx", int'(col_idx), 0);
    chk("rst_res_req", int'(res_req), 0);
    chk("rst_res_tag", int'(res_tag), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    @(posedge pclk);
    #1 rst_n = 1'b1;

    // Frame 1: saturation, partial-length and random lines, 14 lines total
    ack_mode = ACK_RUN;
    frame_begin();
    drive_line(2000);
    drive_line(2100);
    drive_line(750);
    for (int i = 0; i < 11; i++) drive_line(int'($urandom_range(1, 1800)));
    frame_end();
    chk("overrun_clean_f1", int'(overrun), 0);

    // Frame 2: 13 full-block lines, last one beyond the accepted rows
    frame_begin();
    repeat (13) drive_line(BLK_PIX);
    frame_end();

    // Overrun: two completions with ack held low; the second tag is lost
    ack_mode = 0;
    frame_begin();
    drive_line(1000);
    void'(exp_tag_q.pop_back());
    void'(exp_len_q.pop_back());
    @(negedge pclk);
    chk("ovr_req_held", int'(res_req), 1);
    chk("ovr_tag_kept", int'(res_tag), 0);
    chk("ovr_set", int'(overrun), 1);
    ack_mode = 1;
    drain();
    chk("ovr_sticky", int'(overrun), 1);
    frame_end();
    @(negedge pclk);
    chk("ovr_in_vblank", int'(overrun), 1);
    frame_begin();
    @(negedge pclk);
    chk("ovr_cleared", int'(overrun), 0);

    // Reset mid-line while a result is pending
    ack_mode = 0;
    for (int p = 0; p < 600; p++) begin
      @(posedge pclk);
      #1 href = 1'b1;
    end
    @(negedge pclk);
    chk("pre_reset_req", int'(res_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_res_req", int'(res_req), 0);
    chk("mid_rst_res_tag", int'(res_tag), 0);
    chk("mid_rst_col_idx", int'(col_idx), 0);
    chk("mid_rst_acc_en", int'(acc_en), 0);
    chk("mid_rst_acc_clr", int'(acc_clr), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    href = 1'b0;
    @(posedge pclk);
    #1 rst_n = 1'b1;

    // Recovery frame after reset
    ack_mode = ACK_RUN;
    frame_begin();
    drive_line(750);
    drive_line(int'($urandom_range(1, 2200)));
    frame_end();
    chk("overrun_clean_end", int'(overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wcoder_sched.md
Name: wcoder_sched

Overview:
- Frame/line sequencer for the weighted-sum coder datapath on the camera pixel clock.
- Tracks vsync/href and generates per-pixel accumulate controls: enable, clear and column index.
- Tags each completed column block with its row-block and column-block position.
- Passes finished blocks to the byte serializer through a req/ack handshake, with overrun detection.

Parameters:
COL_BLK_W, 500, pixels per column block
COL_W, 9, width of col_idx (must hold COL_BLK_W-1)
NUM_COL_BLKS, 4, column blocks accepted per line; later pixels ignored
ROW_BLK_H, 3, lines per row block
NUM_ROW_BLKS, 4, row blocks accepted per frame; later lines ignored
BLK_W, 2, width of blk_col/blk_row/line_in_blk

Ports:
pclk  in  1  pixel clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
vsync  in  1  frame sync, high during vertical blank
href  in  1  line valid, din valid while high
acc_en  out  1  datapath accumulates din this cycle
acc_clr  out  1  datapath loads din instead of adding (first pixel of block)
col_idx  out  COL_W  index of current pixel within its column block
res_req  out  1  finished block result valid for serializer
res_tag  out  3*BLK_W  {blk_row, blk_col, line_in_blk} of finished block
res_ack  in  1  serializer accepted res_tag
overrun  out  1  sticky: a block finished while previous req unacknowledged
frame_done  out  1  one-cycle pulse at end of active frame

Behaviour:
- Reset values: acc_en=0, acc_clr=0, col_idx=0, res_req=0, res_tag=0, overrun=0, frame_done=0; FSM=S_IDLE.
- Counters: col_idx, blk_col, line_in_blk, blk_row all reset to 0.
- S_IDLE: wait for vsync=1, then go to S_VBLANK. href is ignored.
- S_VBLANK: on vsync falling, clear overrun, blk_row and line_in_blk, then go to S_GAP.
- S_GAP: href=1 enters S_LINE. col_idx and blk_col are already 0.
- S_LINE: href=0 returns to S_GAP and runs line accounting:
  - line_in_blk increments; at ROW_BLK_H-1 it wraps to 0 and blk_row increments.
  - blk_row saturates at NUM_ROW_BLKS, which marks lines as ignored.
- vsync rising in S_GAP or S_LINE: frame_done pulses for 1 cycle and the FSM goes to S_VBLANK.
- acc_en/acc_clr/col_idx are combinational from registered state and href, aligned to din in the same cycle.
  - acc_en = href & in S_GAP/S_LINE & blk_col<NUM_COL_BLKS & blk_row<NUM_ROW_BLKS.
  - acc_clr = acc_en & col_idx==0.
- col_idx increments on each href=1 cycle.
  - At COL_BLK_W-1 it wraps to 0, blk_col increments (saturating at NUM_COL_BLKS), and the block completes.
- Block complete (acc_en & col_idx==COL_BLK_W-1): the next cycle sets res_req=1 with the tag of the finished block. Latency is 1 cycle.
- res_req holds, with res_tag stable, until res_ack=1 is sampled; it drops the following cycle.
- Completion in the same cycle as res_ack: res_req stays 1 with the new tag; no overrun.
- Completion while res_req=1 and res_ack=0: the new tag is dropped, overrun is set, and the old tag is kept.
- href falling mid-block: the partial block is discarded; col_idx and blk_col reset to 0.
- vsync rising mid-line: the line is abandoned. A pending res_req is unaffected.
- rst_n low at any time: immediate return to the reset values.

Optional Feature:
WCODER_SCHED_PARTIAL_EN
- Defined: href falling with acc_en history and col_idx!=0 counts as a block completion (same res_req/overrun rules).
  - res_tag gains a 1-bit partial flag as its MSB.
  - An extra output, part_len (COL_W bits), gives the pixel count and is valid with res_req.
- Undefined: partial blocks are silently discarded; res_tag is 3*BLK_W bits; no part_len port.

Decomposition:
- Package wcoder_pkg holds:
  - FSM state enum (S_IDLE, S_VBLANK, S_GAP, S_LINE).
  - Default geometry constants, shared with the coder and serializer.
  - Tag field offset constants.
- Sub-module wcoder_res_hs (req/ack holding register plus overrun flag) is natural.
- Counters and FSM stay in the top.

Test Plan:
- Reset mid-line with res_req=1 -> all outputs 0 within the reset assertion, FSM S_IDLE.
- vsync pulse, then one line of 2000 href cycles, res_ack tied 1 -> four res_req pulses, tags {0,0,0},{0,1,0},{0,2,0},{0,3,0}.
  - Each req is 1 cycle after col_idx=499.
  - acc_clr high at col_idx=0 only.
- Same line with 2100 href cycles -> acc_en low for pixels 2000-2099; still exactly four results.
- res_ack held 0 across two completions -> overrun=1; tag stays {0,0,0}; overrun clears at the next vsync falling edge.
- 13 lines of 500 pixels -> tags advance line_in_blk 0,1,2 then blk_row+1; line 13 gives no acc_en; vsync rise gives a single frame_done pulse.
- Line of 750 pixels -> without the macro, one result; with WCODER_SCHED_PARTIAL_EN, a second result with the partial flag set and part_len=250.
